// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
//
// MM:SS countdown timer with BCD digits, preset load, start/pause/resume
// control and an alarm output that is raised when the count reaches 00:00.
//
// Parameters
//   TICK_DIV      clock cycles per one-second decrement (must be >= 2)
//
// Ports
//   clock         system clock, all state changes on its rising edge
//   reset         asynchronous active-high reset
//   load          one-cycle pulse: latch clamped set_* digits, go to IDLE
//   start_stop    one-cycle pulse: start / pause / resume / acknowledge alarm
//   set_*         BCD preset digits (clamped to 9 / 5 / 9 / 9 on load)
//   *Disp         registered BCD remaining time
//   state         registered state code: IDLE=0 RUN=1 PAUSE=2 DONE=3
//   alarm         registered, high only in DONE
//
// Build option
//   BCD_COUNTDOWN_ALARM_BLINK_EN  when defined, alarm blinks in DONE with a
//                                 half-period of TICK_DIV/2 cycles, starting
//                                 high on DONE entry; otherwise alarm is
//                                 steady high throughout DONE.
// -----------------------------------------------------------------------------
module bcd_countdown #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       start_stop,
  input  logic [3:0] set_ones_sec,
  input  logic [3:0] set_tens_sec,
  input  logic [3:0] set_ones_min,
  input  logic [3:0] set_tens_min,
  output logic [3:0] onesSecDisp,
  output logic [3:0] tensSecDisp,
  output logic [3:0] onesMinDisp,
  output logic [3:0] tensMinDisp,
  output logic [3:0] state,
  output logic       alarm
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
`ifdef BCD_COUNTDOWN_ALARM_BLINK_EN
  localparam logic [PW-1:0] BLINK_TOP = PW'(TICK_DIV / 2 - 1);
`endif

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RUN   = 4'd1,
    ST_PAUSE = 4'd2,
    ST_DONE  = 4'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_sec_q, ones_sec_d;
  logic [3:0]    tens_sec_q, tens_sec_d;
  logic [3:0]    ones_min_q, ones_min_d;
  logic [3:0]    tens_min_q, tens_min_d;
  logic          alarm_q, alarm_d;

  logic [3:0] clamp_ones_sec, clamp_tens_sec, clamp_ones_min, clamp_tens_min;
  logic [3:0] dec_ones_sec, dec_tens_sec, dec_ones_min, dec_tens_min;
  logic       count_zero, dec_zero, presc_top;

  assign clamp_ones_sec = (set_ones_sec > 4'd9) ? 4'd9 : set_ones_sec;
  assign clamp_tens_sec = (set_tens_sec > 4'd5) ? 4'd5 : set_tens_sec;
  assign clamp_ones_min = (set_ones_min > 4'd9) ? 4'd9 : set_ones_min;
  assign clamp_tens_min = (set_tens_min > 4'd9) ? 4'd9 : set_tens_min;

  assign count_zero = (ones_sec_q == 4'd0) && (tens_sec_q == 4'd0) &&
                      (ones_min_q == 4'd0) && (tens_min_q == 4'd0);
  assign presc_top  = (presc_q == PRESC_TOP);

  // One-second BCD borrow chain. Only used when the count is nonzero, so the
  // tens-of-minutes digit never underflows.
  always_comb begin
    dec_ones_sec = ones_sec_q;
    dec_tens_sec = tens_sec_q;
    dec_ones_min = ones_min_q;
    dec_tens_min = tens_min_q;
    if (ones_sec_q != 4'd0) begin
      dec_ones_sec = ones_sec_q - 4'd1;
    end else begin
      dec_ones_sec = 4'd9;
      if (tens_sec_q != 4'd0) begin
        dec_tens_sec = tens_sec_q - 4'd1;
      end else begin
        dec_tens_sec = 4'd5;
        if (ones_min_q != 4'd0) begin
          dec_ones_min = ones_min_q - 4'd1;
        end else begin
          dec_ones_min = 4'd9;
          dec_tens_min = tens_min_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_ones_sec == 4'd0) && (dec_tens_sec == 4'd0) &&
                    (dec_ones_min == 4'd0) && (dec_tens_min == 4'd0);

  // Next-state / next-output logic. load overrides everything else.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ones_sec_d = ones_sec_q;
    tens_sec_d = tens_sec_q;
    ones_min_d = ones_min_q;
    tens_min_d = tens_min_q;
    alarm_d    = alarm_q;

    if (load) begin
      ones_sec_d = clamp_ones_sec;
      tens_sec_d = clamp_tens_sec;
      ones_min_d = clamp_ones_min;
      tens_min_d = clamp_tens_min;
      state_d    = ST_IDLE;
      presc_d    = '0;
      alarm_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start_stop && !count_zero) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (presc_top && !count_zero) begin
            // A stop request on the terminal cycle still takes the decrement;
            // reaching 00:00 wins over the pause.
            ones_sec_d = dec_ones_sec;
            tens_sec_d = dec_tens_sec;
            ones_min_d = dec_ones_min;
            tens_min_d = dec_tens_min;
            presc_d    = '0;
            if (dec_zero) begin
              state_d = ST_DONE;
              alarm_d = 1'b1;
            end else if (start_stop) begin
              state_d = ST_PAUSE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (start_stop) begin
              state_d = ST_PAUSE;
            end
          end
        end

        ST_PAUSE: begin
          // Prescaler holds so the resumed second keeps its partial count.
          if (start_stop) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          if (start_stop) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
            presc_d = '0;
          end else begin
`ifdef BCD_COUNTDOWN_ALARM_BLINK_EN
            // The alarm register doubles as the blink toggle; the prescaler
            // free-runs over half a second period to pace it.
            if (presc_q == BLINK_TOP) begin
              presc_d = '0;
              alarm_d = ~alarm_q;
            end else begin
              presc_d = presc_q + PW'(1);
            end
`else
            presc_d = '0;
            alarm_d = 1'b1;
`endif
          end
        end

        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      ones_sec_q <= 4'd0;
      tens_sec_q <= 4'd0;
      ones_min_q <= 4'd0;
      tens_min_q <= 4'd0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ones_sec_q <= ones_sec_d;
      tens_sec_q <= tens_sec_d;
      ones_min_q <= ones_min_d;
      tens_min_q <= tens_min_d;
      alarm_q    <= alarm_d;
    end
  end

  assign onesSecDisp = ones_sec_q;
  assign tensSecDisp = tens_sec_q;
  assign onesMinDisp = ones_min_q;
  assign tensMinDisp = tens_min_q;
  assign state       = state_q;
  assign alarm       = alarm_q;

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning CLOCK_50 cycles per one-second decrement (must be >=2).
REQ-002 SHALL have port clock, input, 1, 50 MHz system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port load, input, 1, single-cycle pulse that latches the set_* digits.
REQ-005 SHALL have port start_stop, input, 1, single-cycle pulse that starts, pauses, resumes or acknowledges.
REQ-006 SHALL have ports set_ones_sec, set_tens_sec, set_ones_min and set_tens_min, each input, 4, BCD preset digits.
REQ-007 SHALL have ports onesSecDisp, tensSecDisp, onesMinDisp and tensMinDisp, each output, 4, registered BCD remaining time.
REQ-008 SHALL have port state, output, 4, registered state code with IDLE=0, RUN=1, PAUSE=2 and DONE=3.
REQ-009 SHALL have port alarm, output, 1, registered; high only in DONE.

Function
REQ-010 SHALL clamp digits at load: ones_sec and the minute digits >9 become 9; tens_sec >5 becomes 5.
REQ-011 SHALL, when load is sampled high in any state, latch the clamped digits, enter IDLE, clear the prescaler and deassert alarm.
REQ-012 SHALL give load priority over start_stop when both are high in the same cycle.
REQ-013 SHALL handle start_stop in IDLE: nonzero count goes to RUN with the prescaler cleared; a count of 00:00 stays in IDLE.
REQ-014 SHALL handle start_stop in other states: RUN goes to PAUSE, PAUSE goes to RUN, and DONE goes to IDLE with alarm cleared and the digits held at 00:00.
REQ-015 SHALL run the prescaler 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and hold it at 0 in IDLE and DONE.
REQ-016 SHALL, in RUN with the prescaler at TICK_DIV-1, decrement the time by one second at the next edge and wrap the prescaler to 0, so the first decrement lands TICK_DIV edges after entering RUN.
REQ-017 SHALL decrement as a BCD borrow chain: ones_sec 0 wraps to 9 with borrow; tens_sec 0 wraps to 5 with borrow; ones_min 0 wraps to 9 with borrow; no underflow past 00:00.
REQ-018 SHALL, on the edge where the count becomes 00:00, enter DONE and assert alarm on that same edge.
REQ-019 SHALL, if start_stop arrives in RUN on the terminal-prescaler cycle, both decrement and enter PAUSE, or enter DONE if the count reaches 00:00.
REQ-020 SHALL keep digits stable when not loading or decrementing; the outputs are the internal registers themselves.

Reset
REQ-021 SHALL, while reset is high, immediately force all digit outputs to 0, state to IDLE (0), alarm to 0, prescaler to 0 and the blink toggle to 0.
REQ-022 SHALL discard any run in progress on reset mid-operation; a new load is needed before timing.

Configuration
REQ-023 SHALL support macro BCD_COUNTDOWN_ALARM_BLINK_EN: when defined, alarm in DONE toggles every TICK_DIV/2 cycles, first high on DONE entry, using the prescaler free-running in DONE only for this purpose.
REQ-024 SHALL, with BCD_COUNTDOWN_ALARM_BLINK_EN undefined, hold alarm steady high throughout DONE; all other behaviour is identical.

Verification (TICK_DIV=4)
REQ-025 SHALL cover reset: assert reset mid-RUN at 01:30 -> digits 0000, state 0 and alarm 0 immediately, with no activity after release.
REQ-026 SHALL cover borrow: load 01:05, start_stop -> 01:04 after 4 edges; after 6 decrements (24 edges) -> 00:59, state 1.
REQ-027 SHALL cover pause: from RUN at 00:40, start_stop -> state 2, digits frozen for 50 cycles; start_stop -> state 1, and the next decrement uses the remaining prescaler count.
REQ-028 SHALL cover expiry: load 00:02, start -> 00:01 at edge 4, then 00:00 with state 3 and alarm 1 at edge 8; start_stop -> state 0, alarm 0.
REQ-029 SHALL cover clamp and priority: set digits F,F,F,F with load and start_stop in the same cycle -> 99:59 latched, state 0.
REQ-030 SHALL cover zero start and blink: start_stop at 00:00 in IDLE -> stays 0; with BCD_COUNTDOWN_ALARM_BLINK_EN in DONE -> alarm toggles every 2 cycles.
